bulk_in_arbiter: RTL and testbench

BULK_IN_ARBITER -- requirements
Module: bulk_in_arbiter

---
 rtl/bulk_in_arbiter.sv | 163 ++++++++++++++++
 tb/tb_bulk_in_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bulk_in_arbiter.sv
// bulk_in_arbiter: round-robin arbiter that hands one of NUM_CH byte-stream
// sources to a USB bulk IN endpoint, one max-packet-size packet at a time.
// Optional per-channel packet statistics are compiled in with the macro
// BULK_IN_ARB_STATS_EN (adds output pkt_cnt); without it the port and its
// counters do not exist.
//
// Handshake: on every stream (s_* per channel and blk_xfer_in_data_*) a byte
// moves on a rising clk edge where valid and ready are both 1. A source may
// drop valid at any time (the transfer simply stalls). Ready is driven only
// to the granted channel while in XFER, and never depends on that channel's
// own valid.
module bulk_in_arbiter #(
  parameter int NUM_CH     = 2,
  parameter int HIGH_SPEED = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [8*NUM_CH-1:0]   s_tdata,
  input  logic [NUM_CH-1:0]     s_tvalid,
  input  logic [NUM_CH-1:0]     s_tlast,
  output logic [NUM_CH-1:0]     s_tready,
  input  logic                  blk_in_xfer,
  output logic                  blk_xfer_in_has_data,
  output logic [7:0]            blk_xfer_in_data,
  output logic                  blk_xfer_in_data_valid,
  output logic                  blk_xfer_in_data_last,
  input  logic                  blk_xfer_in_data_ready,
  output logic [NUM_CH-1:0]     grant,
  output logic                  busy,
`ifdef BULK_IN_ARB_STATS_EN
  output logic [16*NUM_CH-1:0]  pkt_cnt,
`endif
  output logic [1:0]            dbg_state
);

  localparam int IW = $clog2(NUM_CH);
  localparam logic [9:0] MPS_M1 = (HIGH_SPEED != 0) ? 10'd511 : 10'd63;
  localparam logic [IW-1:0] LAST_CH = IW'(NUM_CH - 1);
  localparam logic [IW-1:0] IDX_ONE = IW'(1);
  localparam logic [NUM_CH-1:0] CH0_HOT = {{(NUM_CH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    READY    = 2'd1,
    XFER     = 2'd2,
    WAIT_END = 2'd3
  } state_t;

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] gidx;
  logic [9:0]    byte_cnt;
  logic          pkt_trunc;

  logic          arb_found;
  logic [IW-1:0] arb_idx;
  logic [IW-1:0] cand;
  logic          beat;
  logic          pkt_end;

  // Round-robin search: first requesting channel at or after rr_ptr.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = IW'((int'(rr_ptr) + k) % NUM_CH);
      if (!arb_found && s_tvalid[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // Endpoint stream is a straight copy of the granted source while in XFER.
  always_comb begin
    blk_xfer_in_data       = '0;
    blk_xfer_in_data_valid = 1'b0;
    blk_xfer_in_data_last  = 1'b0;
    s_tready               = '0;
    if (state == XFER) begin
      blk_xfer_in_data       = s_tdata[{gidx, 3'b000} +: 8];
      blk_xfer_in_data_valid = s_tvalid[gidx];
      blk_xfer_in_data_last  = s_tlast[gidx] | (byte_cnt == MPS_M1);
      s_tready[gidx]         = blk_xfer_in_data_ready;
    end
  end

  assign beat                 = blk_xfer_in_data_valid & blk_xfer_in_data_ready;
  assign pkt_end              = beat & blk_xfer_in_data_last;
  assign blk_xfer_in_has_data = (state == READY) || (state == XFER);
  assign busy                 = (state != IDLE);
  assign dbg_state            = state;

  // Packet FSM: grant, wait for the IN token, stream, wait for the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gidx      <= '0;
      grant     <= '0;
      byte_cnt  <= '0;
      pkt_trunc <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_found) begin
            gidx  <= arb_idx;
            grant <= CH0_HOT << arb_idx;
            state <= READY;
          end
        end
        READY: begin
          if (blk_in_xfer) begin
            byte_cnt <= '0;
            state    <= XFER;
          end
        end
        XFER: begin
          if (beat) begin
            byte_cnt <= byte_cnt + 10'd1;
          end
          if (pkt_end) begin
            // A packet cut at MPS keeps the channel's turn so the frame completes.
            pkt_trunc <= ~s_tlast[gidx];
            state     <= WAIT_END;
          end else if (!blk_in_xfer) begin
            // Aborted transaction: drop the grant, keep rr_ptr, no replay.
            byte_cnt <= '0;
            grant    <= '0;
            state    <= IDLE;
          end
        end
        WAIT_END: begin
          if (!blk_in_xfer) begin
            if (!pkt_trunc) begin
              rr_ptr <= (gidx == LAST_CH) ? '0 : gidx + IDX_ONE;
            end
            grant <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BULK_IN_ARB_STATS_EN
  // Per-channel count of packets closed by a data_last beat, wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (pkt_end && (gidx == IW'(c))) begin
          pkt_cnt[16*c +: 16] <= pkt_cnt[16*c +: 16] + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_bulk_in_arbiter.sv
// tb_bulk_in_arbiter: directed bench for bulk_in_arbiter (NUM_CH=2, full-speed
// MPS of 64). Source and endpoint stream models run in the background; the
// expected endpoint byte stream {channel, last, data} is queued as frames are
// loaded and compared beat by beat.
module tb_bulk_in_arbiter;

  localparam int NUM_CH = 2;
  localparam int MPS    = 64;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READY = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd3;

  logic                 clk;
  logic                 rst;
  logic [8*NUM_CH-1:0]  s_tdata;
  logic [NUM_CH-1:0]    s_tvalid;
  logic [NUM_CH-1:0]    s_tlast;
  logic [NUM_CH-1:0]    s_tready;
  logic                 blk_in_xfer;
  logic                 has_data;
  logic [7:0]           ep_data;
  logic                 ep_valid;
  logic                 ep_last;
  logic                 blk_xfer_in_data_ready;
  logic [NUM_CH-1:0]    grant;
  logic                 busy;
  logic [1:0]           dbg_state;
`ifdef BULK_IN_ARB_STATS_EN
  logic [16*NUM_CH-1:0] pkt_cnt;
`endif

  int tests = 0;
  int fails = 0;
  int beats_done = 0;
  int exp_pkt [NUM_CH];
  logic ep_en, tog_en, gap_en, rdy_phase;

  logic [8:0]  src_q [NUM_CH][$];
  logic [10:0] exp_q [$];

  bulk_in_arbiter #(.NUM_CH(NUM_CH), .HIGH_SPEED(0)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .s_tdata                (s_tdata),
    .s_tvalid               (s_tvalid),
    .s_tlast                (s_tlast),
    .s_tready               (s_tready),
    .blk_in_xfer            (blk_in_xfer),
    .blk_xfer_in_has_data   (has_data),
    .blk_xfer_in_data       (ep_data),
    .blk_xfer_in_data_valid (ep_valid),
    .blk_xfer_in_data_last  (ep_last),
    .blk_xfer_in_data_ready (blk_xfer_in_data_ready),
    .grant                  (grant),
    .busy                   (busy),
`ifdef BULK_IN_ARB_STATS_EN
    .pkt_cnt                (pkt_cnt),
`endif
    .dbg_state              (dbg_state)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] gnt_idx(input logic [NUM_CH-1:0] g);
    case (g)
      2'b01:   return 2'd0;
      2'b10:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  // Queue a frame on a source and the endpoint bytes it should produce
  // (first n_exp bytes), splitting packets at MPS.
  task automatic load_frame(input int ch, input int n, input int n_exp);
    int k;
    logic [7:0] d;
    logic l, l_exp;
    k = 0;
    for (int i = 0; i < n; i++) begin
      d = 8'($urandom_range(0, 255));
      l = (i == n - 1);
      src_q[ch].push_back({l, d});
      l_exp = l || (k == MPS - 1);
      if (i < n_exp) exp_q.push_back({2'(ch), l_exp, d});
      k = l_exp ? 0 : k + 1;
    end
  endtask

  task automatic wait_state(input logic [1:0] st, input int max_cyc, input string tag);
    int n;
    n = 0;
    while (dbg_state !== st && n < max_cyc) begin
      @(posedge clk); #2;
      n++;
    end
    check(tag, 32'(dbg_state), 32'(st));
  endtask

  task automatic wait_beats(input int target, input int max_cyc, input string tag);
    int n;
    n = 0;
    while (beats_done < target && n < max_cyc) begin
      @(posedge clk); #2;
      n++;
    end
    check(tag, 32'(beats_done), 32'(target));
  endtask

  // One complete packet on channel ch, granted and closed by the endpoint.
  task automatic do_packet(input int ch);
    wait_state(ST_READY, 100, "reach_ready");
    check("has_data_ready", 32'(has_data), 1);
    check("grant", 32'(grant), 32'(1 << ch));
    check("busy_ready", 32'(busy), 1);
    blk_in_xfer = 1'b1;
    wait_state(ST_WAIT, 3000, "reach_wait_end");
    check("has_data_wait_end", 32'(has_data), 0);
    blk_in_xfer = 1'b0;
    @(posedge clk); #2;
    check("idle_after_end", 32'(dbg_state), 32'(ST_IDLE));
    check("grant_cleared", 32'(grant), 0);
    exp_pkt[ch]++;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_has_data"}, 32'(has_data), 0);
    check({tag, "_valid"}, 32'(ep_valid), 0);
    check({tag, "_last"}, 32'(ep_last), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_tready"}, 32'(s_tready), 0);
    check({tag, "_data"}, 32'(ep_data), 0);
    check({tag, "_grant"}, 32'(grant), 0);
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

`ifdef BULK_IN_ARB_STATS_EN
  task automatic check_stats(input string tag);
    check({tag, "_pkt_cnt0"}, 32'(pkt_cnt[15:0]), 32'(exp_pkt[0]));
    check({tag, "_pkt_cnt1"}, 32'(pkt_cnt[31:16]), 32'(exp_pkt[1]));
  endtask
`endif

  // Source/endpoint stream models and scoreboard.
  initial begin : stream
    logic [NUM_CH-1:0] fire;
    logic [10:0] obs, e;
    logic [8:0] head;
    logic gap;
    forever begin
      @(negedge clk);
      fire = s_tvalid & s_tready;
      if (ep_valid && blk_xfer_in_data_ready) begin
        obs = {gnt_idx(grant), ep_last, ep_data};
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $error("FAIL unexpected_beat: observed 0x%0h expected no beat", obs);
        end else begin
          e = exp_q.pop_front();
          check("beat", 32'(obs), 32'(e));
        end
      end
      @(posedge clk); #1;
      if (fire != '0) beats_done++;
      for (int c = 0; c < NUM_CH; c++) begin
        if (fire[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
        gap = gap_en && ($urandom_range(0, 2) == 0);
        if (src_q[c].size() > 0) begin
          head = src_q[c][0];
          s_tvalid[c] = !gap;
          s_tdata[8*c +: 8] = head[7:0];
          s_tlast[c] = head[8];
        end else begin
          s_tvalid[c] = 1'b0;
          s_tdata[8*c +: 8] = 8'h00;
          s_tlast[c] = 1'b0;
        end
      end
      rdy_phase = ~rdy_phase;
      blk_xfer_in_data_ready = ep_en && (!tog_en || rdy_phase);
    end
  end

  // Directed sequence.
  initial begin
    int base;
    rst = 1'b1;
    blk_in_xfer = 1'b0;
    s_tvalid = '0;
    s_tdata = '0;
    s_tlast = '0;
    blk_xfer_in_data_ready = 1'b0;
    ep_en = 1'b1;
    tog_en = 1'b0;
    gap_en = 1'b0;
    rdy_phase = 1'b0;
    exp_pkt[0] = 0;
    exp_pkt[1] = 0;

    // Both channels hold two 4-byte frames from reset.
    load_frame(0, 4, 4);
    load_frame(1, 4, 4);
    load_frame(0, 4, 4);
    load_frame(1, 4, 4);
    #3;
    check_quiet("reset");
    repeat (3) @(posedge clk);
    #2;
    check("reset_valid_held_has_data", 32'(has_data), 0);
    check("reset_valid_held_grant", 32'(grant), 0);
    rst = 1'b0;

    // Alternating grants 0,1,0,1.
    do_packet(0);
    do_packet(1);
    do_packet(0);
    do_packet(1);

    // 100-byte frame on ch0 split at MPS; ch0 keeps priority over waiting ch1.
    load_frame(0, 100, 100);
    load_frame(1, 4, 4);
    do_packet(0);
    do_packet(0);
    do_packet(1);

    // Abort after 10 of 20 bytes; ch0 is regranted ahead of waiting ch1.
    load_frame(0, 20, 20);
    load_frame(1, 4, 4);
    wait_state(ST_READY, 100, "abort_reach_ready");
    check("abort_grant", 32'(grant), 32'b01);
    blk_in_xfer = 1'b1;
    base = beats_done;
    wait_beats(base + 10, 200, "abort_ten_beats");
    blk_in_xfer = 1'b0;
    ep_en = 1'b0;
    blk_xfer_in_data_ready = 1'b0;
    @(posedge clk); #2;
    check("abort_state_idle", 32'(dbg_state), 32'(ST_IDLE));
    check("abort_grant_cleared", 32'(grant), 0);
    check("abort_busy", 32'(busy), 0);
    ep_en = 1'b1;
    do_packet(0);
    do_packet(1);

    // Ready toggling and source gaps: 70-byte frame still splits at byte 64.
    tog_en = 1'b1;
    gap_en = 1'b1;
    load_frame(1, 70, 70);
    do_packet(1);
    do_packet(1);
    tog_en = 1'b0;
    gap_en = 1'b0;
`ifdef BULK_IN_ARB_STATS_EN
    check_stats("stats");
`endif

    // Move rr_ptr to 1, then reset in the middle of a ch1 packet.
    load_frame(0, 4, 4);
    load_frame(1, 30, 5);
    do_packet(0);
    wait_state(ST_READY, 100, "rst_reach_ready");
    check("rst_grant", 32'(grant), 32'b10);
    blk_in_xfer = 1'b1;
    base = beats_done;
    wait_beats(base + 5, 200, "rst_five_beats");
    rst = 1'b1;
    blk_in_xfer = 1'b0;
    #1;
    check_quiet("mid_rst");
    exp_pkt[0] = 0;
    exp_pkt[1] = 0;
`ifdef BULK_IN_ARB_STATS_EN
    check_stats("mid_rst");
`endif
    src_q[1].delete();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;

    // First grant after reset starts from channel 0.
    load_frame(0, 4, 4);
    load_frame(1, 4, 4);
    do_packet(0);
    do_packet(1);
`ifdef BULK_IN_ARB_STATS_EN
    check_stats("post_rst");
`endif

    repeat (3) @(posedge clk);
    #2;
    check("exp_q_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
